// File: rtl/flopenr_pkg.sv
// flopenr_pkg: shared definitions for the byte-lane enable/reset register family.
//   BYTE_W - width of one write-strobe lane in bits
//   lanes  - number of byte lanes in a register of the given width
//   word_t - native 32-bit datapath word
package flopenr_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [31:0] word_t;

  function automatic int unsigned lanes(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/flopenr_lane.sv
// flopenr_lane: one 8-bit byte lane with synchronous active-low reset and load enable.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous reset, active-low; loads RESET_VAL
//   en  - lane load enable, active-high
//   d   - lane data in
//   q   - lane data out (registered)
module flopenr_lane
  import flopenr_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);

  // Mux form rather than if(en) so an unknown enable shows up on q instead
  // of silently holding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else begin
      q <= en ? d : q;
    end
  end

endmodule

// File: rtl/flopenr32_reg.sv
// flopenr32_reg: WIDTH-bit data register with synchronous active-low reset,
// load enable and per-byte write strobes. Output is purely registered.
// Ports:
//   clk    - clock, all state changes on rising edge
//   rst    - synchronous reset, active-low; q <= RESET_VAL, loaded <= 0
//   clr    - (only with FLOPENR32_CLEAR_EN) synchronous clear, active-high;
//            same effect as reset, lower priority than rst, higher than en
//   en     - load enable, active-high
//   be     - byte-lane write strobes; be[i] gates d[8i+7:8i]
//   d      - data to load
//   q      - registered data
//   loaded - set once any byte has been written since the last reset/clear
// Build option: define FLOPENR32_CLEAR_EN to add the clr input.
module flopenr32_reg
  import flopenr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FLOPENR32_CLEAR_EN
  input  logic               clr,
`endif
  input  logic               en,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic               loaded
);

  localparam int unsigned NLANES = lanes(WIDTH);

  // Reset and clear have identical effect, so they fold into one
  // active-low lane reset; rst still wins because either forces reset.
  logic lane_rst;

`ifdef FLOPENR32_CLEAR_EN
  assign lane_rst = rst & ~clr;
`else
  assign lane_rst = rst;
`endif

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    flopenr_lane #(
      .RESET_VAL (RESET_VAL[i*BYTE_W +: BYTE_W])
    ) u_lane (
      .clk (clk),
      .rst (lane_rst),
      .en  (en & be[i]),
      .d   (d[i*BYTE_W +: BYTE_W]),
      .q   (q[i*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!lane_rst) begin
      loaded <= 1'b0;
    end else begin
      loaded <= loaded | (en & (|be));
    end
  end

endmodule

// File: tb/tb_flopenr32_reg.sv
module tb_flopenr32_reg;
  import flopenr_pkg::*;

  localparam int unsigned NL = 4;
  localparam word_t RV = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_t = 1'b1;
  logic          clr_t = 1'b0;
  logic          en_t = 1'b0;
  logic [NL-1:0] be_t = '0;
  word_t         d_t = '0;
  word_t         q;
  logic          loaded;

  int vectors = 0;
  int miscompares = 0;

  flopenr32_reg #(
    .WIDTH     (32),
    .RESET_VAL (RV)
  ) dut (
    .clk    (clk),
    .rst    (rst_t),
`ifdef FLOPENR32_CLEAR_EN
    .clr    (clr_t),
`endif
    .en     (en_t),
    .be     (be_t),
    .d      (d_t),
    .q      (q),
    .loaded (loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register as an array of bytes plus a "written" flag.
  logic [7:0] m_b [NL];
  bit         m_loaded = 1'b0;
  bit         m_valid  = 1'b0;

  function automatic word_t model_word();
    word_t w;
    for (int i = 0; i < NL; i++) w[8*i +: 8] = m_b[i];
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_t || (m_valid && clr_t)) begin
      for (int i = 0; i < NL; i++) m_b[i] = RV[8*i +: 8];
      m_loaded = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid && en_t) begin
      for (int i = 0; i < NL; i++)
        if (be_t[i]) m_b[i] = d_t[8*i +: 8];
      if (be_t != 0) m_loaded = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("q_vs_model", q, model_word());
      check("loaded_vs_model", {31'b0, loaded}, {31'b0, m_loaded});
    end
  end

  // Apply one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic cyc(input logic r, input logic c, input logic e,
                     input logic [NL-1:0] b, input word_t dd);
    @(negedge clk);
    rst_t = r; clr_t = c; en_t = e; be_t = b; d_t = dd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    word_t held;

    // 1: reset overrides a full load
    cyc(1'b0, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
    check("reset_q", q, 32'h0000_0000);
    check("reset_loaded", {31'b0, loaded}, 32'd0);

    // 2: full load, q unchanged until the edge
    @(negedge clk);
    rst_t = 1'b1; en_t = 1'b1; be_t = 4'hF; d_t = 32'h1234_5678;
    #1;
    check("pre_edge_q", q, 32'h0000_0000);
    @(posedge clk); #2;
    check("load_q", q, 32'h1234_5678);
    check("load_loaded", {31'b0, loaded}, 32'd1);

    // 3: hold while d toggles
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF);
    check("hold_q0", q, 32'h1234_5678);
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0000);
    check("hold_q1", q, 32'h1234_5678);
    cyc(1'b1, 1'b0, 1'b0, 4'hA, 32'hFFFF_FFFF);
    check("hold_q2", q, 32'h1234_5678);

    // 4: partial write of lanes 0 and 2
    cyc(1'b1, 1'b0, 1'b1, 4'b0101, 32'hAABB_CCDD);
    check("partial_q", q, 32'h12BB_56DD);

    // en with no strobes changes nothing
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, 32'h0F0F_0F0F);
    check("be0_q", q, 32'h12BB_56DD);
    check("be0_loaded", {31'b0, loaded}, 32'd1);

    // 5: reset mid-stream discards a simultaneous load
    cyc(1'b0, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D);
    check("midreset_q", q, RV);
    check("midreset_loaded", {31'b0, loaded}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 32'hCAFE_F00D);
    check("after_reset_hold_q", q, RV);

    // loaded stays low when enabled with no strobes
    cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h5555_5555);
    check("be0_after_reset_loaded", {31'b0, loaded}, 32'd0);

    // single upper-lane write sets loaded
    cyc(1'b1, 1'b0, 1'b1, 4'b1000, 32'h9900_0000);
    check("lane3_q", q, 32'h9900_0000);
    check("lane3_loaded", {31'b0, loaded}, 32'd1);

`ifdef FLOPENR32_CLEAR_EN
    // 6: clear beats enable, then load proceeds once clear drops
    cyc(1'b1, 1'b0, 1'b1, 4'hF, 32'h0000_00FF);
    check("pre_clr_q", q, 32'h0000_00FF);
    cyc(1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0001);
    check("clr_q", q, 32'h0000_0000);
    check("clr_loaded", {31'b0, loaded}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'hF, 32'h0000_0001);
    check("post_clr_q", q, 32'h0000_0001);
    // reset beats clear
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 32'h7777_7777);
    check("rst_over_clr_q", q, RV);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      logic r, c, e;
      logic [NL-1:0] b;
      r = ($urandom_range(0, 19) != 0);
`ifdef FLOPENR32_CLEAR_EN
      c = ($urandom_range(0, 14) == 0);
`else
      c = 1'b0;
`endif
      e = $urandom_range(0, 1);
      b = NL'($urandom_range(0, 15));
      cyc(r, c, e, b, $urandom);
    end

    // Final hold sanity check against the captured value
    held = q;
    cyc(1'b1, 1'b0, 1'b0, 4'hF, ~held);
    check("final_hold_q", q, held);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
